eeprom_page_scheduler: RTL and testbench
========================================

// Module: eeprom_page_scheduler
// PURPOSE
// - Sequences 64-byte page writes of the data logger's 512-bit cache into the 24LC256 EEPROM.
// - Sits between the sample cache and the I2C leader:
//   - accepts a full cache page, issues one leader transfer with the page address,
//   - waits out the write cycle (Twc), retries on NACK,
//   - advances the address through the 32 KB array.
// - Raises mem_full when the array is exhausted (no wrap) and error after repeated NACKs.
// PARAMETERS
// - PAGE_BYTES  64      bytes per page write; address step
// - ADDR_W      15      EEPROM byte-address width (32 KB)
// - TWC_CYCLES  250000  write-cycle wait in CLK_50MHz cycles (5 ms)
// - MAX_RETRY   3       NACK retries per page before error
// - WRAP_EN     0       1: wrap to BASE_ADDR after last page; 0: stop with mem_full
// - BASE_ADDR   0       first page address; must be PAGE_BYTES-aligned
// PORTS
// - CLK_50MHz      in   1      system clock
// - RESET          in   1      reset, asynchronous, active-low
// - cache_data     in   512    page to write; bit 8k+7..8k = byte k, byte 0 at the lowest address
// - cache_valid    in   1      cache page available
// - cache_ready    out  1      scheduler accepts a page this cycle
// - clear          in   1      soft restart: address to BASE_ADDR, clears mem_full/error
// - i2c_start      out  1      one-cycle pulse: leader begins a page transfer
// - i2c_addr       out  ADDR_W page start address for the leader
// - i2c_page       out  512    latched page data for the leader
// - i2c_done       in   1      one-cycle pulse: leader transfer finished
// - i2c_nack       in   1      qualifies i2c_done: transfer was NACKed
// - mem_full       out  1      array exhausted (WRAP_EN=0)
// - error          out  1      retries exhausted on the current page
// - pages_written  out  10     count of successfully written pages, saturating at 512
// BEHAVIOUR
// - Reset values:
//   - state=IDLE, cache_ready=0 in the reset cycle (1 from the first clocked IDLE cycle)
//   - i2c_start=0, i2c_addr=BASE_ADDR, i2c_page=0
//   - mem_full=0, error=0, pages_written=0, retry=0
// - States: IDLE, ISSUE, WAIT_XFER, WAIT_TWC, ADVANCE, FULL, ERROR. All outputs are registered.
// - IDLE:
//   - cache_ready=1.
//   - On cache_valid&&cache_ready: latch cache_data into i2c_page on the same edge, retry=0, go to ISSUE.
// - ISSUE: i2c_start=1 for exactly one cycle, then WAIT_XFER.
//   - i2c_addr/i2c_page stay stable from ISSUE until leaving WAIT_TWC.
// - WAIT_XFER: wait for i2c_done.
//   - !i2c_nack: go to WAIT_TWC, marked success.
//   - i2c_nack && retry<MAX_RETRY: retry++, go to WAIT_TWC, marked retry.
//   - i2c_nack && retry==MAX_RETRY: go to ERROR.
// - WAIT_TWC: load the timer with TWC_CYCLES-1 on entry and count to 0.
//   - Success: go to ADVANCE. Retry: go to ISSUE.
//   - Minimum gap from i2c_done to the next i2c_start is TWC_CYCLES+1 cycles.
// - ADVANCE: pages_written++ (saturating), i2c_addr += PAGE_BYTES (mod 2^ADDR_W).
//   - Wrapped result && !WRAP_EN: address held at BASE_ADDR, mem_full=1, go to FULL.
//   - Wrapped result && WRAP_EN: address = BASE_ADDR, go to IDLE.
//   - Otherwise: go to IDLE.
// - FULL / ERROR: cache_ready=0; flags held until clear or RESET.
// - clear is honoured only in IDLE, FULL and ERROR.
//   - Effect: i2c_addr=BASE_ADDR, mem_full=0, error=0, pages_written=0, go to IDLE.
//   - Ignored in all other states; the transfer completes.
// - clear && cache_valid in IDLE in the same cycle: clear wins, the page is not accepted.
// - Stray i2c_done outside WAIT_XFER is ignored. i2c_nack without i2c_done is ignored.
// - RESET mid-transfer: return to the reset state immediately.
//   - The leader is reset by the same RESET; no page or address is retained.
// - Throughput: one page per transfer time + TWC_CYCLES + 3 cycles.
// STRUCTURE
// - Package eeprom_pkg holds:
//   - state enum sched_state_t
//   - EEPROM_BYTES=32768, PAGE_BYTES=64, PAGE_BITS=512
//   - TWC_5MS_50MHZ=250000
// - Sub-module eeprom_twc_timer: 18-bit loadable down-counter (load, value, zero flag).
// - Everything else lives in the FSM and the address/page registers in this file.
// TESTING
// - Reset then a page of bytes 0x00..0x3F:
//   - cache_ready drops, one i2c_start with i2c_addr=0x0000,
//   - done without NACK -> after TWC_CYCLES, i2c_addr=0x0040, pages_written=1, cache_ready=1.
// - NACK twice then ACK: exactly 3 i2c_start pulses, each >= TWC_CYCLES+1 after the prior done;
//   - error=0, pages_written=1.
// - NACK MAX_RETRY+1 times: error=1, cache_ready=0.
//   - clear -> error=0, i2c_addr=BASE_ADDR, cache_ready=1.
// - WRAP_EN=0, 512 pages (TWC_CYCLES=4):
//   - last page at 0x7FC0, then mem_full=1 and pages_written=512;
//   - a further cache_valid is never accepted.
// - WRAP_EN=1: page 513 is issued at i2c_addr=0x0000; mem_full stays 0.
// - Mid-transfer and other corner cases:
//   - RESET asserted in WAIT_XFER -> all outputs return to reset values in the same cycle.
//   - clear && cache_valid in IDLE in the same cycle -> no i2c_start.

Source files
------------

// File: rtl/eeprom_pkg.sv
// Shared types and constants for the EEPROM page scheduler and its write-cycle timer.
package eeprom_pkg;

  localparam int EEPROM_BYTES  = 32768;
  localparam int PAGE_BYTES    = 64;
  localparam int PAGE_BITS     = 512;
  localparam int TWC_5MS_50MHZ = 250000;
  localparam int TIMER_W       = 18;
  localparam int PAGES_W       = 10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_XFER,
    WAIT_TWC,
    ADVANCE,
    FULL,
    ERROR
  } sched_state_t;

endpackage

// File: rtl/eeprom_twc_timer.sv
// Loadable down-counter that times the EEPROM internal write cycle; parks at zero.
module eeprom_twc_timer
  import eeprom_pkg::*;
(
  input  logic               CLK_50MHz,
  input  logic               RESET,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/eeprom_page_scheduler.sv
// Writes cache pages into the 24LC256 one page per leader transfer, waiting out Twc,
// retrying NACKed pages and stepping the page address through the array.
module eeprom_page_scheduler
  import eeprom_pkg::*;
#(
  parameter int                PAGE_BYTES = eeprom_pkg::PAGE_BYTES,
  parameter int                ADDR_W     = 15,
  parameter int                TWC_CYCLES = TWC_5MS_50MHZ,
  parameter int                MAX_RETRY  = 3,
  parameter bit                WRAP_EN    = 1'b0,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                 CLK_50MHz,
  input  logic                 RESET,
  input  logic [PAGE_BITS-1:0] cache_data,
  input  logic                 cache_valid,
  output logic                 cache_ready,
  input  logic                 clear,
  output logic                 i2c_start,
  output logic [ADDR_W-1:0]    i2c_addr,
  output logic [PAGE_BITS-1:0] i2c_page,
  input  logic                 i2c_done,
  input  logic                 i2c_nack,
  output logic                 mem_full,
  output logic                 error,
  output logic [PAGES_W-1:0]   pages_written,
  output sched_state_t         dbgState
);

  localparam int                 RETRY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [TIMER_W-1:0] TWC_LOAD    = TIMER_W'(TWC_CYCLES - 1);
  localparam logic [ADDR_W:0]    ADDR_STEP   = (ADDR_W + 1)'(PAGE_BYTES);
  localparam logic [PAGES_W-1:0] PAGES_SAT   = PAGES_W'(512);

  sched_state_t       state, nextState;
  logic [RETRY_W-1:0] retry;
  logic               xferOk;
  logic               timerZero;
  logic               acceptPage, doClear, loadTimer, bumpRetry, enterError;
  logic [ADDR_W:0]    addrSum;

  // Carry out of the address add marks the step past the last page of the array.
  assign addrSum  = {1'b0, i2c_addr} + ADDR_STEP;
  assign dbgState = state;

  eeprom_twc_timer u_twcTimer (
    .CLK_50MHz (CLK_50MHz),
    .RESET     (RESET),
    .load      (loadTimer),
    .value     (TWC_LOAD),
    .zero      (timerZero)
  );

  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Handshake: a page moves on a clock edge where cache_valid and cache_ready are both high;
  // cache_data must be stable while cache_valid is high, and the producer may hold valid.
  always_comb begin
    nextState  = state;
    acceptPage = 1'b0;
    doClear    = 1'b0;
    loadTimer  = 1'b0;
    bumpRetry  = 1'b0;
    enterError = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          doClear = 1'b1;
        end else if (cache_valid && cache_ready) begin
          acceptPage = 1'b1;
          nextState  = ISSUE;
        end
      end
      ISSUE: nextState = WAIT_XFER;
      WAIT_XFER: begin
        if (i2c_done) begin
          if (!i2c_nack) begin
            loadTimer = 1'b1;
            nextState = WAIT_TWC;
          end else if (retry < RETRY_LIMIT) begin
            loadTimer = 1'b1;
            bumpRetry = 1'b1;
            nextState = WAIT_TWC;
          end else begin
            enterError = 1'b1;
            nextState  = ERROR;
          end
        end
      end
      WAIT_TWC: begin
        if (timerZero) begin
          nextState = xferOk ? ADVANCE : ISSUE;
        end
      end
      ADVANCE: nextState = (addrSum[ADDR_W] && !WRAP_EN) ? FULL : IDLE;
      FULL, ERROR: begin
        if (clear) begin
          doClear   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      cache_ready   <= 1'b0;
      i2c_start     <= 1'b0;
      i2c_addr      <= BASE_ADDR;
      i2c_page      <= '0;
      mem_full      <= 1'b0;
      error         <= 1'b0;
      pages_written <= '0;
      retry         <= '0;
      xferOk        <= 1'b0;
    end else begin
      cache_ready <= (nextState == IDLE);
      i2c_start   <= (nextState == ISSUE);
      if (acceptPage) begin
        i2c_page <= cache_data;
        retry    <= '0;
      end
      if (bumpRetry) begin
        retry <= retry + 1'b1;
      end
      if (loadTimer) begin
        xferOk <= !i2c_nack;
      end
      if (enterError) begin
        error <= 1'b1;
      end
      if (state == ADVANCE) begin
        if (pages_written != PAGES_SAT) begin
          pages_written <= pages_written + 1'b1;
        end
        if (addrSum[ADDR_W]) begin
          i2c_addr <= BASE_ADDR;
          if (!WRAP_EN) begin
            mem_full <= 1'b1;
          end
        end else begin
          i2c_addr <= addrSum[ADDR_W-1:0];
        end
      end
      if (doClear) begin
        i2c_addr      <= BASE_ADDR;
        mem_full      <= 1'b0;
        error         <= 1'b0;
        pages_written <= '0;
      end
    end
  end

endmodule

// File: tb/tb_eeprom_page_scheduler.sv
// Randomized scoreboard bench for eeprom_page_scheduler with a leader model and a page-level reference model.
module tb_eeprom_page_scheduler;
  import eeprom_pkg::*;

  localparam int TWC       = 4;
  localparam int MAX_RETRY = 3;
  localparam int ADDR_W    = 15;
  localparam int W         = 1 + ADDR_W + 512;

  logic                CLK_50MHz = 1'b0;
  logic                RESET = 1'b0;
  logic [511:0]        cache_data = '0;
  logic                cache_valid = 1'b0;
  logic                clear = 1'b0;
  logic                i2c_done = 1'b0;
  logic                i2c_nack = 1'b0;
  logic                cache_ready, i2c_start, mem_full, error;
  logic [ADDR_W-1:0]   i2c_addr;
  logic [511:0]        i2c_page;
  logic [9:0]          pages_written;
  sched_state_t        dbgState;
  logic                w_cache_ready, w_i2c_start, w_mem_full, w_error;
  logic [ADDR_W-1:0]   w_i2c_addr;
  logic [511:0]        w_i2c_page;
  logic [9:0]          w_pages_written;
  sched_state_t        w_dbgState;

  eeprom_page_scheduler #(.TWC_CYCLES(TWC), .MAX_RETRY(MAX_RETRY), .WRAP_EN(1'b0)) dut (
    .CLK_50MHz(CLK_50MHz), .RESET(RESET), .cache_data(cache_data), .cache_valid(cache_valid),
    .cache_ready(cache_ready), .clear(clear), .i2c_start(i2c_start), .i2c_addr(i2c_addr),
    .i2c_page(i2c_page), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .mem_full(mem_full),
    .error(error), .pages_written(pages_written), .dbgState(dbgState)
  );

  eeprom_page_scheduler #(.TWC_CYCLES(TWC), .MAX_RETRY(MAX_RETRY), .WRAP_EN(1'b1)) dutWrap (
    .CLK_50MHz(CLK_50MHz), .RESET(RESET), .cache_data(cache_data), .cache_valid(cache_valid),
    .cache_ready(w_cache_ready), .clear(clear), .i2c_start(w_i2c_start), .i2c_addr(w_i2c_addr),
    .i2c_page(w_i2c_page), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .mem_full(w_mem_full),
    .error(w_error), .pages_written(w_pages_written), .dbgState(w_dbgState)
  );

  // clock / reset timebase
  always #10 CLK_50MHz = ~CLK_50MHz;
  int cyc = 0;
  always @(posedge CLK_50MHz) cyc <= cyc + 1;

  // scoreboard state and reference model
  logic [W-1:0] exp_q[$];
  bit           nack_q[$];
  int           checks = 0, passes = 0, startCnt = 0, lastDoneCyc = 0;
  bit           autoLeader = 1'b1;
  int           mAddr = 0, mPages = 0;
  bit           mFull = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
  endtask

  task automatic checkPage(input string name, input logic [511:0] act, input logic [511:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  function automatic logic [511:0] randPage();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // monitor: every leader start must match the next expected transfer
  always @(negedge CLK_50MHz) begin : monitor
    logic [W-1:0] e;
    if (RESET && i2c_start) begin
      startCnt++;
      check("start_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("start_addr", i2c_addr, e[W-2 -: ADDR_W]);
        checkPage("start_page", i2c_page, e[511:0]);
        if (e[W-1]) check("retry_gap", cyc - lastDoneCyc, TWC + 1);
      end
    end
  end

  // leader model: random latency, stray nack without done, optional stray done during Twc
  initial begin : leader
    int lat;
    bit nk;
    forever begin
      @(negedge CLK_50MHz);
      if (RESET && autoLeader && i2c_start) begin
        lat = $urandom_range(1, 4);
        repeat (lat) begin
          @(posedge CLK_50MHz); #1;
          i2c_nack = 1'($urandom_range(0, 1));
        end
        @(posedge CLK_50MHz); #1;
        nk = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        i2c_done = 1'b1;
        i2c_nack = nk;
        lastDoneCyc = cyc;
        @(posedge CLK_50MHz); #1;
        if ($urandom_range(0, 1) == 1) begin
          i2c_done = 1'b1;
          i2c_nack = 1'($urandom_range(0, 1));
        end else begin
          i2c_done = 1'b0;
          i2c_nack = 1'b0;
        end
        @(posedge CLK_50MHz); #1;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
      end
    end
  end

  task automatic sendPage(input logic [511:0] data, input int nacks);
    int starts;
    bit got, fin;
    logic [ADDR_W-1:0] a;
    starts = (nacks > MAX_RETRY) ? MAX_RETRY + 1 : nacks + 1;
    a = mAddr[ADDR_W-1:0];
    for (int i = 0; i < starts; i++) begin
      exp_q.push_back({(i > 0), a, data});
      nack_q.push_back(i < nacks);
    end
    repeat ($urandom_range(0, 2)) @(posedge CLK_50MHz);
    @(posedge CLK_50MHz); #1;
    cache_data = data;
    cache_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK_50MHz);
      got = cache_ready;
    end
    check("accept", got, 1);
    @(posedge CLK_50MHz); #1;
    cache_valid = 1'b0;
    cache_data = randPage();
    if (!got) return;
    @(negedge CLK_50MHz);
    check("ready_drop", cache_ready, 0);
    fin = 1'b0;
    for (int i = 0; i < 20 * (TWC + 10) && !fin; i++) begin
      @(negedge CLK_50MHz);
      fin = cache_ready || error || mem_full;
    end
    check("page_finish", fin, 1);
    if (nacks > MAX_RETRY) begin
      check("error_set", error, 1);
      check("error_ready", cache_ready, 0);
      check("error_pages", pages_written, mPages);
    end else begin
      check("done_to_ready", cyc - lastDoneCyc, TWC + 2);
      mPages = (mPages < 512) ? mPages + 1 : 512;
      mAddr = mAddr + 64;
      if (mAddr >= 32768) begin
        mAddr = 0;
        mFull = 1'b1;
      end
      check("addr_next", i2c_addr, mAddr);
      check("pages", pages_written, mPages);
      check("mem_full", mem_full, mFull);
      check("no_error", error, 0);
      check("ready_back", cache_ready, !mFull);
    end
  endtask

  task automatic pulseClear();
    @(posedge CLK_50MHz); #1;
    clear = 1'b1;
    @(posedge CLK_50MHz); #1;
    clear = 1'b0;
    mAddr = 0;
    mPages = 0;
    mFull = 1'b0;
    @(negedge CLK_50MHz);
  endtask

  task automatic pulseReset();
    @(posedge CLK_50MHz); #1;
    RESET = 1'b0;
    repeat (2) @(posedge CLK_50MHz);
    #1 RESET = 1'b1;
    mAddr = 0;
    mPages = 0;
    mFull = 1'b0;
    repeat (2) @(negedge CLK_50MHz);
  endtask

  initial begin : watchdog
    #(20 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [511:0] d;
    int s0;
    bit sawReady, wStart;
    logic [ADDR_W-1:0] wAddr;

    // reset values
    @(negedge CLK_50MHz);
    check("rst_ready", cache_ready, 0);
    check("rst_start", i2c_start, 0);
    check("rst_addr", i2c_addr, 0);
    checkPage("rst_page", i2c_page, '0);
    check("rst_full", mem_full, 0);
    check("rst_error", error, 0);
    check("rst_pages", pages_written, 0);
    @(posedge CLK_50MHz); #1 RESET = 1'b1;
    @(posedge CLK_50MHz);
    @(negedge CLK_50MHz);
    check("ready_after_rst", cache_ready, 1);

    // bytes 0x00..0x3F, clean ACK
    for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(k);
    sendPage(d, 0);

    // NACK twice then ACK
    s0 = startCnt;
    sendPage(randPage(), 2);
    check("nack2_starts", startCnt - s0, 3);

    for (int i = 0; i < 6; i++) sendPage(randPage(), $urandom_range(0, 3));

    // retries exhausted, then clear
    sendPage(randPage(), MAX_RETRY + 1);
    pulseClear();
    check("clr_error", error, 0);
    check("clr_addr", i2c_addr, 0);
    check("clr_ready", cache_ready, 1);
    check("clr_pages", pages_written, 0);

    // fill the whole array
    for (int i = 0; i < 512; i++) sendPage(randPage(), $urandom_range(0, 1));
    check("full_flag", mem_full, 1);
    check("full_pages", pages_written, 512);

    // main instance refuses more pages; wrapping instance issues at address 0
    s0 = startCnt;
    sawReady = 1'b0;
    wStart = 1'b0;
    wAddr = '1;
    @(posedge CLK_50MHz); #1;
    cache_data = randPage();
    cache_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_50MHz);
      if (cache_ready) sawReady = 1'b1;
      if (w_i2c_start && !wStart) begin
        wStart = 1'b1;
        wAddr = w_i2c_addr;
      end
    end
    @(posedge CLK_50MHz); #1 cache_valid = 1'b0;
    check("full_no_accept", sawReady, 0);
    check("full_no_start", startCnt - s0, 0);
    check("wrap_start", wStart, 1);
    check("wrap_addr", wAddr, 0);
    check("wrap_no_full", w_mem_full, 0);
    check("wrap_pages", w_pages_written, 512);

    pulseReset();

    // clear and cache_valid together in IDLE
    s0 = startCnt;
    @(posedge CLK_50MHz); #1;
    clear = 1'b1;
    cache_valid = 1'b1;
    cache_data = randPage();
    @(posedge CLK_50MHz); #1;
    clear = 1'b0;
    cache_valid = 1'b0;
    repeat (8) @(negedge CLK_50MHz);
    check("clear_wins", startCnt - s0, 0);
    check("clear_wins_ready", cache_ready, 1);

    // RESET while waiting on the leader
    sendPage(randPage(), 0);
    autoLeader = 1'b0;
    d = randPage();
    exp_q.push_back({1'b0, mAddr[ADDR_W-1:0], d});
    @(posedge CLK_50MHz); #1;
    cache_data = d;
    cache_valid = 1'b1;
    wStart = 1'b0;
    for (int i = 0; i < 40 && !wStart; i++) begin
      @(negedge CLK_50MHz);
      if (i2c_start) wStart = 1'b1;
      if (!cache_ready) cache_valid = 1'b0;
    end
    cache_valid = 1'b0;
    check("mid_start_seen", wStart, 1);
    repeat (2) @(posedge CLK_50MHz);
    #2 RESET = 1'b0;
    #1;
    check("mid_rst_ready", cache_ready, 0);
    check("mid_rst_start", i2c_start, 0);
    check("mid_rst_addr", i2c_addr, 0);
    checkPage("mid_rst_page", i2c_page, '0);
    check("mid_rst_full", mem_full, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_pages", pages_written, 0);
    @(posedge CLK_50MHz); #1 RESET = 1'b1;
    autoLeader = 1'b1;
    mAddr = 0;
    mPages = 0;
    mFull = 1'b0;
    repeat (2) @(negedge CLK_50MHz);
    check("post_rst_ready", cache_ready, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
